// File: rtl/nanorv32_mem_xbar.sv
// nanorv32_mem_xbar: code/data port to NBANKS single-port RAM interconnect.
// Define NRV32_MEM_RR_ARB_EN for per-bank round-robin conflict arbitration.
module nanorv32_mem_xbar #(
  parameter int NBANKS  = 2,
  parameter int BANK_AW = 13
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [31:0]               cpu_codemem_addr,
  input  logic                      cpu_codemem_valid,
  output logic [31:0]               codemem_cpu_rdata,
  output logic                      codemem_cpu_ready,
  input  logic [31:0]               cpu_datamem_addr,
  input  logic [31:0]               cpu_datamem_wdata,
  input  logic [3:0]                cpu_datamem_bytesel,
  input  logic                      cpu_datamem_wr,
  input  logic                      cpu_datamem_valid,
  output logic [31:0]               datamem_cpu_rdata,
  output logic                      datamem_cpu_ready,
  output logic [NBANKS*BANK_AW-1:0] bank_addr,
  output logic [NBANKS*4-1:0]       bank_we,
  output logic [NBANKS*32-1:0]      bank_din,
  input  logic [NBANKS*32-1:0]      bank_dout
);

  localparam int UW = 30 - BANK_AW;
  localparam int BW = (NBANKS > 1) ? $clog2(NBANKS) : 1;

  typedef enum logic {IDLE, RESP} st_t;

  st_t               code_st, data_st;
  logic [BW-1:0]     code_lat_idx, data_lat_idx;
  logic              code_lat_oor, data_lat_oor;
  logic              data_lat_wr;

  logic [UW-1:0]      code_sel, data_sel;
  logic [BANK_AW-1:0] code_word, data_word;
  logic [BW-1:0]      code_idx, data_idx;
  logic               code_oor, data_oor;
  logic               code_req, data_req;
  logic               conflict, data_wins;
  logic               code_gnt, data_gnt;
  logic               unused_bits;

  assign code_sel  = cpu_codemem_addr[31:BANK_AW+2];
  assign data_sel  = cpu_datamem_addr[31:BANK_AW+2];
  assign code_word = cpu_codemem_addr[BANK_AW+1:2];
  assign data_word = cpu_datamem_addr[BANK_AW+1:2];
  assign code_idx  = code_sel[BW-1:0];
  assign data_idx  = data_sel[BW-1:0];
  assign code_oor  = code_sel >= UW'(NBANKS);
  assign data_oor  = data_sel >= UW'(NBANKS);

  assign unused_bits = ^{cpu_codemem_addr[1:0], cpu_datamem_addr[1:0]};

  assign code_req = cpu_codemem_valid & (code_st == IDLE) & ~code_oor;
  assign data_req = cpu_datamem_valid & (data_st == IDLE) & ~data_oor;
  assign conflict = code_req & data_req & (code_idx == data_idx);

`ifdef NRV32_MEM_RR_ARB_EN
  logic [NBANKS-1:0] rr_code;

  assign data_wins = ~rr_code[data_idx];

  // Flip the bank's turn bit each time that bank resolves a conflict
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_code <= '0;
    end else if (conflict) begin
      rr_code[data_idx] <= ~rr_code[data_idx];
    end
  end
`else
  assign data_wins = 1'b1;
`endif

  assign code_gnt = code_req & ~(conflict & data_wins);
  assign data_gnt = data_req & ~(conflict & ~data_wins);

  // Code port: accept a granted or out-of-range request, respond next cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      code_st      <= IDLE;
      code_lat_idx <= '0;
      code_lat_oor <= 1'b0;
    end else begin
      unique case (code_st)
        IDLE: begin
          if (code_gnt || (cpu_codemem_valid && code_oor)) begin
            code_st      <= RESP;
            code_lat_idx <= code_idx;
            code_lat_oor <= code_oor;
          end
        end
        RESP: code_st <= IDLE;
        default: code_st <= IDLE;
      endcase
    end
  end

  // Data port: same handshake, also remembers whether it was a write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_st      <= IDLE;
      data_lat_idx <= '0;
      data_lat_oor <= 1'b0;
      data_lat_wr  <= 1'b0;
    end else begin
      unique case (data_st)
        IDLE: begin
          if (data_gnt || (cpu_datamem_valid && data_oor)) begin
            data_st      <= RESP;
            data_lat_idx <= data_idx;
            data_lat_oor <= data_oor;
            data_lat_wr  <= cpu_datamem_wr;
          end
        end
        RESP: data_st <= IDLE;
        default: data_st <= IDLE;
      endcase
    end
  end

  // Route the granted port onto each bank; writes are killed while in reset
  always_comb begin
    bank_addr = '0;
    bank_we   = '0;
    bank_din  = '0;
    for (int k = 0; k < NBANKS; k++) begin
      bank_din[k*32 +: 32] = cpu_datamem_wdata;
      if (code_gnt && code_idx == BW'(k)) begin
        bank_addr[k*BANK_AW +: BANK_AW] = code_word;
      end
      if (data_gnt && data_idx == BW'(k)) begin
        bank_addr[k*BANK_AW +: BANK_AW] = data_word;
        if (cpu_datamem_wr && rst_n) begin
          bank_we[k*4 +: 4] = cpu_datamem_bytesel;
        end
      end
    end
  end

  assign codemem_cpu_ready = (code_st == RESP);
  assign datamem_cpu_ready = (data_st == RESP);

  assign codemem_cpu_rdata =
    (code_st == RESP && !code_lat_oor) ?
    bank_dout[int'(code_lat_idx)*32 +: 32] : '0;

  assign datamem_cpu_rdata =
    (data_st == RESP && !data_lat_oor && !data_lat_wr) ?
    bank_dout[int'(data_lat_idx)*32 +: 32] : '0;

endmodule

// File: tb/tb_nanorv32_mem_xbar.sv
// tb_nanorv32_mem_xbar: random and directed checks of the memory crossbar
// against a transaction-level model of grants, latency and memory contents.
module tb_nanorv32_mem_xbar;

  localparam int NB = 2;
  localparam int AW = 13;
  localparam int WPB = 1 << AW;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [31:0]       code_addr;
  logic              code_valid;
  logic [31:0]       codemem_cpu_rdata;
  logic              codemem_cpu_ready;
  logic [31:0]       data_addr;
  logic [31:0]       data_wdata;
  logic [3:0]        data_bs;
  logic              data_wr;
  logic              data_valid;
  logic [31:0]       datamem_cpu_rdata;
  logic              datamem_cpu_ready;
  logic [NB*AW-1:0]  bank_addr;
  logic [NB*4-1:0]   bank_we;
  logic [NB*32-1:0]  bank_din;
  logic [NB*32-1:0]  bank_dout;

  int checks = 0;
  int errors = 0;

  bit [31:0]   ram [NB*WPB];
  logic [31:0] ref_mem [int];
  bit          rr_turn [NB];

  always #5 clk = ~clk;

  nanorv32_mem_xbar #(.NBANKS(NB), .BANK_AW(AW)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .cpu_codemem_addr    (code_addr),
    .cpu_codemem_valid   (code_valid),
    .codemem_cpu_rdata   (codemem_cpu_rdata),
    .codemem_cpu_ready   (codemem_cpu_ready),
    .cpu_datamem_addr    (data_addr),
    .cpu_datamem_wdata   (data_wdata),
    .cpu_datamem_bytesel (data_bs),
    .cpu_datamem_wr      (data_wr),
    .cpu_datamem_valid   (data_valid),
    .datamem_cpu_rdata   (datamem_cpu_rdata),
    .datamem_cpu_ready   (datamem_cpu_ready),
    .bank_addr           (bank_addr),
    .bank_we             (bank_we),
    .bank_din            (bank_din),
    .bank_dout           (bank_dout)
  );

  function automatic logic [31:0] init_word(input int key);
    logic [31:0] k;
    k = 32'(key + 1);
    return (k * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old,
                                        input logic [31:0] d,
                                        input logic [3:0] bs);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++)
      if (bs[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  // Synchronous single-port RAM banks; array holds the delta from init_word
  always @(posedge clk) begin
    for (int b = 0; b < NB; b++) begin
      int          key;
      logic [31:0] cur;
      key = b * WPB + int'(bank_addr[b*AW +: AW]);
      cur = ram[key] ^ init_word(key);
      bank_dout[b*32 +: 32] <= cur;
      if (bank_we[b*4 +: 4] != 4'b0)
        ram[key] <= merge(cur, bank_din[b*32 +: 32], bank_we[b*4 +: 4])
                    ^ init_word(key);
    end
  end

  function automatic logic [31:0] ref_rd(input int key);
    return ref_mem.exists(key) ? ref_mem[key] : init_word(key);
  endfunction

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic xact(input bit cv, input logic [31:0] ca,
                      input bit dv, input logic [31:0] da,
                      input bit dw, input logic [31:0] dd,
                      input logic [3:0] bs);
    int          cb, db, ck, dk;
    bit          coor, door, conf, cfirst, c0, d0;
    logic [31:0] cexp, dexp;
    logic [7:0]  we;
    cb = int'(ca >> (AW + 2));
    db = int'(da >> (AW + 2));
    coor = cb >= NB;
    door = db >= NB;
    ck = cb * WPB + int'(ca[AW+1:2]);
    dk = db * WPB + int'(da[AW+1:2]);
    conf = cv && dv && !coor && !door && cb == db;
    cfirst = 1'b0;
`ifdef NRV32_MEM_RR_ARB_EN
    if (conf) begin
      cfirst = rr_turn[cb];
      rr_turn[cb] = !rr_turn[cb];
    end
`endif
    c0 = cv && !(conf && !cfirst);
    d0 = dv && !(conf && cfirst);
    cexp = '0;
    dexp = '0;
    @(negedge clk);
    code_valid = cv;
    code_addr  = ca;
    data_valid = dv;
    data_addr  = da;
    data_wr    = dw;
    data_wdata = dd;
    data_bs    = bs;
    for (int p = 0; p < 2; p++) begin
      bit gc, gd;
      gc = (p == 0) ? c0 : (cv && !c0);
      gd = (p == 0) ? d0 : (dv && !d0);
      if (p == 0 || gc || gd) begin
        we = '0;
        if (gd) begin
          if (dw) begin
            dexp = '0;
            if (!door) begin
              we[db*4 +: 4] = bs;
              ref_mem[dk] = merge(ref_rd(dk), dd, bs);
            end
          end else begin
            dexp = door ? 32'h0 : ref_rd(dk);
          end
        end
        if (gc) cexp = coor ? 32'h0 : ref_rd(ck);
        if (p == 1) @(negedge clk);
        #1;
        check("bank_we", {56'h0, bank_we}, {56'h0, we});
        @(posedge clk);
        #1;
        check("code_ready", {63'h0, codemem_cpu_ready}, {63'h0, gc});
        check("data_ready", {63'h0, datamem_cpu_ready}, {63'h0, gd});
        check("code_rdata", {32'h0, codemem_cpu_rdata},
              {32'h0, gc ? cexp : 32'h0});
        check("data_rdata", {32'h0, datamem_cpu_rdata},
              {32'h0, gd ? dexp : 32'h0});
        if (gc) code_valid = 1'b0;
        if (gd) data_valid = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    check("idle_code_ready", {63'h0, codemem_cpu_ready}, 64'h0);
    check("idle_data_ready", {63'h0, datamem_cpu_ready}, 64'h0);
  endtask

  task automatic reset_idle_checks(input string tag);
    check({tag, "_code_ready"}, {63'h0, codemem_cpu_ready}, 64'h0);
    check({tag, "_data_ready"}, {63'h0, datamem_cpu_ready}, 64'h0);
    check({tag, "_code_rdata"}, {32'h0, codemem_cpu_rdata}, 64'h0);
    check({tag, "_data_rdata"}, {32'h0, datamem_cpu_rdata}, 64'h0);
    check({tag, "_bank_we"}, {56'h0, bank_we}, 64'h0);
  endtask

  task automatic mid_reset();
    @(negedge clk);
    code_valid = 1'b1;
    code_addr  = 32'h0000_0010;
    @(posedge clk);
    #1;
    check("pre_rst_ready", {63'h0, codemem_cpu_ready}, 64'h1);
    rst_n      = 1'b0;
    data_valid = 1'b1;
    data_addr  = 32'h0000_8008;
    data_wr    = 1'b1;
    data_wdata = 32'hCAFE_F00D;
    data_bs    = 4'hF;
    #1;
    reset_idle_checks("rst_async");
    @(posedge clk);
    #1;
    reset_idle_checks("rst_hold");
    @(negedge clk);
    code_valid = 1'b0;
    data_valid = 1'b0;
    rst_n      = 1'b1;
    for (int b = 0; b < NB; b++) rr_turn[b] = 1'b0;
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    case ($urandom_range(0, 9))
      0: a = $urandom;
      1: a = (32'd2 << (AW + 2)) | 32'($urandom_range(0, 7) << 2);
      default: a = (32'($urandom_range(0, NB - 1)) << (AW + 2))
                 | 32'($urandom_range(0, 7) << 2)
                 | 32'($urandom_range(0, 3));
    endcase
    return a;
  endfunction

  initial begin
    rst_n      = 1'b0;
    code_valid = 1'b0;
    code_addr  = '0;
    data_valid = 1'b0;
    data_addr  = '0;
    data_wr    = 1'b0;
    data_wdata = '0;
    data_bs    = '0;
    repeat (3) @(posedge clk);
    #1;
    reset_idle_checks("reset");
    @(negedge clk);
    rst_n = 1'b1;

    xact(0, 0, 1, 32'h0000_0010, 1, 32'hDEAD_BEEF, 4'hF);
    xact(1, 32'h0000_0010, 0, 0, 0, 0, 4'h0);
    check("code_deadbeef", {32'h0, ref_rd(4)}, 64'hDEAD_BEEF);

    xact(0, 0, 1, 32'h0000_8004, 1, 32'h1122_3344, 4'b0011);
    xact(0, 0, 1, 32'h0000_8004, 0, 0, 4'h0);
    check("half_write", {48'h0, ref_rd(WPB + 1) & 32'hFFFF}, 64'h3344);

    xact(1, 32'h0000_0000, 1, 32'h0000_0100, 0, 0, 4'h0);
    xact(1, 32'h0000_0000, 1, 32'h0000_0100, 0, 0, 4'h0);
    xact(1, 32'h0000_0010, 1, 32'h0000_0010, 1, 32'h0BAD_CAFE, 4'hF);
    xact(1, 32'h0000_0010, 1, 32'h0000_8004, 0, 0, 4'h0);
    xact(0, 0, 1, 32'h0001_0000, 1, 32'h5555_AAAA, 4'hF);
    xact(1, 32'hFFFF_FFF0, 1, 32'h0000_8000, 0, 0, 4'h0);

    mid_reset();
    xact(0, 0, 1, 32'h0000_8008, 0, 0, 4'h0);
    xact(1, 32'h0000_0010, 0, 0, 0, 0, 4'h0);

    for (int i = 0; i < 400; i++) begin
      logic [31:0] ca, da;
      ca = rand_addr();
      da = rand_addr();
      xact($urandom_range(0, 3) != 0, ca,
           $urandom_range(0, 3) != 0, da,
           1'($urandom_range(0, 1)), $urandom, 4'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
